pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform, such as the motor drive `pwm` pin or an external RC/servo signal, and reports period, high time and duty in percent. It is the receive-side counterpart to the PWM generator: it closes the loop for self-test and lets a host check the drive signal actually on the pin. It sits between an I/O pin and the register/LED logic, in the single `clk_16mhz` domain.

## Interface
Parameters:
- `CLK_FREQUENCY`, 16_000_000: system clock in Hz.
- `MIN_PWM_FREQUENCY`, 1_000: slowest PWM measured, in Hz.
- `MAX_COUNT` (localparam) = CLK_FREQUENCY/MIN_PWM_FREQUENCY: timeout count, 16000 by default.
- `COUNT_BITS` (localparam) = $clog2(MAX_COUNT+1): 14 by default.

Ports:
- `clk_16mhz`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pwm_in`  in  1  asynchronous PWM input.
- `period`  out  COUNT_BITS  clocks between successive rising edges; reset 0.
- `high_count`  out  COUNT_BITS  clocks from rising edge to falling edge; reset 0.
- `duty_pct`  out  7  high_count*100/period, truncated, 0..100; reset 0.
- `valid`  out  1  one-cycle pulse when a new measurement is published; reset 0.
- `stuck`  out  1  level: no edge for MAX_COUNT cycles; reset 0.
- `level`  out  1  synchronized input level captured when `stuck` sets; reset 0.

## Operation
- Synchronizer: 3-flop chain s1→s2→s3, all reset to 1.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
  - Because the chain resets to 1, an input already high at reset release produces no false rise.
- FSM states:
  - IDLE: on rise → HIGH, cnt←1.
  - HIGH: cnt increments each cycle. On fall → LOW, hi_tmp←cnt.
  - LOW: cnt increments each cycle. On rise → HIGH, cnt←1, publish (period←cnt, high_count←hi_tmp).
- Counting: the cycle after a rise is count 1. This makes `period` and `high_count` exact clock counts; both edges see the same synchronizer latency.
- Saturation and timeout:
  - If cnt reaches MAX_COUNT in HIGH or LOW, set `stuck`=1, set `level`=s2, and go to IDLE.
  - Nothing is published on timeout; `period`, `high_count` and `duty_pct` hold their last values.
- `stuck` clears on the next rise. The first `valid` after that requires one full period.
- Duty 0% (steady low) and 100% (steady high) are reported only through `stuck` + `level`.
- `period`, `high_count` and `duty_pct` change only on publish and hold otherwise.
- Divider (only with PWM_CAPTURE_DUTY_EN):
  - Restoring shift-subtract.
  - Numerator high_count*100, width COUNT_BITS+7; divisor period.
  - 7 quotient bits, one bit per cycle.
  - Starts on publish.
  - A new publish while busy restarts it with the new operands; the older result is discarded and its `valid` is not issued.
- Reset asserted mid-operation:
  - Aborts immediately to IDLE.
  - All outputs return to reset values; no `valid`.

## Timing
- Latency from a pin edge to rise/fall detection: 3 clocks (constant, so it cancels out of the measurements).
- Publish occurs on the closing-rise cycle N; `period` and `high_count` are visible from N+1.
- `valid` timing:
  - Without PWM_CAPTURE_DUTY_EN: pulses at N+1.
  - With it: pulses at N+8, together with the updated `duty_pct`.
- Minimum measurable period: 2×3 clocks at the pin. Shorter pulses are lost in the synchronizer.
- With the divider, periods under 8 clocks yield no `valid`.
- `stuck` asserts on the cycle cnt reaches MAX_COUNT.

## Configuration
- `PWM_CAPTURE_DUTY_EN`:
  - Defined: the iterative divider is compiled in, `duty_pct` is live, and `valid` latency is 8 cycles.
  - Undefined: no divider logic, `duty_pct` tied to 0, and `valid` latency is 1 cycle.

## Test plan
- 100 kHz, 20% input (160 clocks, 32 high) → `period`=160, `high_count`=32, `duty_pct`=20 (EN) with a single-cycle `valid` each period. No `valid` for the first, partial period.
- Switch to 50 kHz, 75% → the first complete new period reports 320/240/75; earlier outputs hold until then.
- Hold `pwm_in` high for 16000+ clocks → `stuck`=1, `level`=1, no `valid`, and outputs hold their last values. A subsequent 100 kHz input clears `stuck` on its first rise, and `valid` follows one period later.
- Hold `pwm_in` low after a valid train → `stuck`=1, `level`=0 exactly MAX_COUNT clocks after the last rise/fall.
- Assert `reset` mid-high-phase → all outputs 0 immediately, no `valid`, and measurement restarts cleanly on the next full period.
- 1-clock glitches on `pwm_in` → recorded counts stay consistent, with no X and no `valid` faster than one per complete period.

Source files
------------

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM period, high time and duty; flags a stuck input.
// Define PWM_CAPTURE_DUTY_EN to build the iterative duty divider (valid then lags publish by 8).
module pwm_capture #(
  parameter  int CLK_FREQUENCY     = 16_000_000,
  parameter  int MIN_PWM_FREQUENCY = 1_000,
  localparam int MAX_COUNT         = CLK_FREQUENCY / MIN_PWM_FREQUENCY,
  localparam int COUNT_BITS        = $clog2(MAX_COUNT + 1)
) (
  input  logic                  clk_16mhz,
  input  logic                  reset,
  input  logic                  pwm_in,
  output logic [COUNT_BITS-1:0] period,
  output logic [COUNT_BITS-1:0] high_count,
  output logic [6:0]            duty_pct,
  output logic                  valid,
  output logic                  stuck,
  output logic                  level
);

  localparam logic [COUNT_BITS-1:0] LIMIT = COUNT_BITS'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_s1;
  logic                  r_s2;
  logic                  r_s3;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_at_limit;
  logic                  w_publish;
  logic                  w_capture_hi;
  logic                  w_timeout;
  logic [COUNT_BITS-1:0] r_cnt;
  logic [COUNT_BITS-1:0] r_hi_tmp;
  logic [COUNT_BITS-1:0] r_period;
  logic [COUNT_BITS-1:0] r_high_count;
  logic                  r_valid;
  logic                  r_stuck;
  logic                  r_level;

  // Chain resets high so a pin already high at reset release is not taken as a rise.
  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise     = r_s2 & ~r_s3;
  assign w_fall     = ~r_s2 & r_s3;
  assign w_at_limit = (r_cnt == LIMIT);

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Timeout wins over a fall in HIGH so the count can never pass MAX_COUNT.
  always_comb begin
    w_next_state = r_state;
    w_publish    = 1'b0;
    w_capture_hi = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_next_state = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_at_limit) begin
          w_next_state = ST_IDLE;
          w_timeout    = 1'b1;
        end else if (w_fall) begin
          w_next_state = ST_LOW;
          w_capture_hi = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          w_next_state = ST_HIGH;
          w_publish    = 1'b1;
        end else if (w_at_limit) begin
          w_next_state = ST_IDLE;
          w_timeout    = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_hi_tmp     <= '0;
      r_period     <= '0;
      r_high_count <= '0;
      r_stuck      <= 1'b0;
      r_level      <= 1'b0;
    end else begin
      if (w_rise) begin
        r_cnt <= COUNT_BITS'(1);
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + COUNT_BITS'(1);
      end
      if (w_capture_hi) begin
        r_hi_tmp <= r_cnt;
      end
      if (w_publish) begin
        r_period     <= r_cnt;
        r_high_count <= r_hi_tmp;
      end
      if (w_timeout) begin
        r_stuck <= 1'b1;
        r_level <= r_s2;
      end else if (w_rise) begin
        r_stuck <= 1'b0;
      end
    end
  end

`ifdef PWM_CAPTURE_DUTY_EN
  localparam int NUM_BITS = COUNT_BITS + 7;

  logic [NUM_BITS-1:0] w_num;
  logic [NUM_BITS-1:0] w_trial;
  logic                w_ge;
  logic [NUM_BITS-1:0] r_rem;
  logic [NUM_BITS-1:0] r_dsh;
  logic [5:0]          r_quo;
  logic [6:0]          r_duty;
  logic [2:0]          r_div_left;

  // Quotient is at most 100, so seven trial subtractions of period<<6..period<<0 suffice.
  assign w_num   = NUM_BITS'(r_hi_tmp) * NUM_BITS'(100);
  assign w_ge    = (r_rem >= r_dsh);
  assign w_trial = r_rem - r_dsh;

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      r_rem      <= '0;
      r_dsh      <= '0;
      r_quo      <= '0;
      r_duty     <= '0;
      r_div_left <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_publish) begin
        r_rem      <= w_num;
        r_dsh      <= NUM_BITS'(r_cnt) << 6;
        r_quo      <= '0;
        r_div_left <= 3'd7;
      end else if (r_div_left != 3'd0) begin
        if (w_ge) begin
          r_rem <= w_trial;
        end
        r_dsh      <= r_dsh >> 1;
        r_quo      <= {r_quo[4:0], w_ge};
        r_div_left <= r_div_left - 3'd1;
        if (r_div_left == 3'd1) begin
          r_duty  <= {r_quo, w_ge};
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign duty_pct = r_duty;
`else
  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_publish;
    end
  end

  assign duty_pct = 7'd0;
`endif

  assign period     = r_period;
  assign high_count = r_high_count;
  assign valid      = r_valid;
  assign stuck      = r_stuck;
  assign level      = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture with a sample-level reference model
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int MAX_COUNT = 16000;
  localparam int CB        = 14;
`ifdef PWM_CAPTURE_DUTY_EN
  localparam bit DUTY_EN   = 1'b1;
  localparam int VALID_LAT = 9;
`else
  localparam bit DUTY_EN   = 1'b0;
  localparam int VALID_LAT = 2;
`endif

  logic          clk_16mhz = 1'b0;
  logic          reset     = 1'b1;
  logic          pwm_in    = 1'b0;
  logic [CB-1:0] period;
  logic [CB-1:0] high_count;
  logic [6:0]    duty_pct;
  logic          valid;
  logic          stuck;
  logic          level;

  pwm_capture dut (
    .clk_16mhz  (clk_16mhz),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_count (high_count),
    .duty_pct   (duty_pct),
    .valid      (valid),
    .stuck      (stuck),
    .level      (level)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  typedef struct {
    int     per;
    int     hi;
    int     duty;
    longint due;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  int     hi_len;
  int     lo_len;

  // Reference model state: pin samples indexed by clock edge number.
  bit     m_prev      = 1'b1;
  bit     m_meas      = 1'b0;
  bit     m_seen_fall = 1'b0;
  longint m_rise      = 0;
  longint m_fall      = 0;
  bit     m_stuck     = 1'b0;
  bit     m_level     = 1'b0;
  bit     pend_v      = 1'b0;
  exp_t   pend;
  longint pend_k      = 0;
  bit     dly_s[2];
  bit     dly_l[2];
  bit     exp_stuck   = 1'b0;
  bit     exp_level   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1; m_meas = 1'b0; m_seen_fall = 1'b0;
    m_stuck = 1'b0; m_level = 1'b0; pend_v = 1'b0;
    sb_q.delete();
    dly_s[0] = 1'b0; dly_s[1] = 1'b0; dly_l[0] = 1'b0; dly_l[1] = 1'b0;
    exp_stuck = 1'b0; exp_level = 1'b0;
  endtask

  task automatic publish(input longint p, input longint h, input longint k);
    exp_t e;
    e.per  = int'(p);
    e.hi   = int'(h);
    e.duty = DUTY_EN ? int'((h * 100) / p) : 0;
    e.due  = k + VALID_LAT;
    if (DUTY_EN) begin
      pend = e; pend_v = 1'b1; pend_k = k;
    end else begin
      sb_q.push_back(e);
    end
  endtask

  task automatic model_step(input bit v);
    bit is_rise;
    bit is_fall;
    is_rise = v && !m_prev;
    is_fall = !v && m_prev;
    // A divider result survives only if no newer period closes within 8 samples.
    if (DUTY_EN && pend_v && (cyc - pend_k == 8)) begin
      sb_q.push_back(pend);
      pend_v = 1'b0;
    end
    if (m_meas && (cyc - m_rise == MAX_COUNT - 1) && !is_rise) begin
      m_meas = 1'b0; m_stuck = 1'b1; m_level = v;
    end else if (is_rise) begin
      if (m_meas && m_seen_fall) publish(cyc - m_rise, m_fall - m_rise, cyc);
      m_meas = 1'b1; m_seen_fall = 1'b0; m_rise = cyc; m_stuck = 1'b0;
    end else if (is_fall && m_meas) begin
      m_seen_fall = 1'b1; m_fall = cyc;
    end
    m_prev = v;
    exp_stuck = dly_s[1]; exp_level = dly_l[1];
    dly_s[1] = dly_s[0]; dly_l[1] = dly_l[0];
    dly_s[0] = m_stuck;  dly_l[0] = m_level;
  endtask

  always @(posedge clk_16mhz) begin
    cyc++;
    if (reset) model_reset();
    else model_step(pwm_in);
  end

  logic prev_stuck = 1'b0;
  bit   prev_exp   = 1'b0;

  always @(negedge clk_16mhz) begin
    exp_t e;
    if (!reset) begin
      if (valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got valid=1 expected 0 (period=%0d high=%0d cycle %0d)",
                   period, high_count, cyc);
        end else begin
          e = sb_q.pop_front();
          check("period", longint'(period), e.per);
          check("high_count", longint'(high_count), e.hi);
          check("duty_pct", longint'(duty_pct), e.duty);
          check("valid_cycle", cyc, e.due);
        end
      end
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missing_valid: got valid=0 expected 1 at cycle %0d", sb_q[0].due);
        void'(sb_q.pop_front());
      end
      if ((stuck !== prev_stuck) || (exp_stuck != prev_exp)) begin
        check("stuck", longint'(stuck), exp_stuck);
        if (exp_stuck) check("level", longint'(level), exp_level);
      end
      prev_stuck = stuck;
      prev_exp   = exp_stuck;
    end else begin
      prev_stuck = 1'b0;
      prev_exp   = 1'b0;
    end
  end

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge clk_16mhz);
      pwm_in = v;
    end
  endtask

  task automatic pwm(input int hi, input int lo, input int reps);
    repeat (reps) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, longint'(period), 0);
    check({tag, "_high_count"}, longint'(high_count), 0);
    check({tag, "_duty_pct"}, longint'(duty_pct), 0);
    check({tag, "_valid"}, longint'(valid), 0);
    check({tag, "_stuck"}, longint'(stuck), 0);
    check({tag, "_level"}, longint'(level), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_16mhz);
    check_reset_outputs("por");
    reset = 1'b0;
    hold(1'b0, 20);

    pwm(32, 128, 8);
    pwm(240, 80, 6);

    hold(1'b1, MAX_COUNT + 100);
    hold(1'b0, 128);
    pwm(32, 128, 4);

    hold(1'b1, 32);
    hold(1'b0, MAX_COUNT + 100);

    repeat (4) begin
      hold(1'b1, 10); hold(1'b0, 1); hold(1'b1, 21);
      hold(1'b0, 60); hold(1'b1, 1); hold(1'b0, 67);
    end

    repeat (60) begin
      hi_len = int'($urandom_range(1, 40));
      lo_len = int'($urandom_range(1, 40));
      if ($urandom_range(0, 5) == 0) hi_len += int'($urandom_range(100, 400));
      hold(1'b1, hi_len);
      hold(1'b0, lo_len);
    end

    pwm(32, 128, 3);
    hold(1'b1, 4);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid");
    repeat (3) @(negedge clk_16mhz);
    reset = 1'b0;
    hold(1'b1, 5);
    hold(1'b0, 100);
    pwm(32, 128, 3);
    hold(1'b0, 40);

    check("queue_drained", longint'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
